// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared out-of-order core types and widths for the result bus
package ooo_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int TAG_WIDTH     = 6;
  localparam int ROB_IDX_WIDTH = 5;

  localparam int CDB_SRC_INT = 0;
  localparam int CDB_SRC_MEM = 1;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]     tag;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
    logic [DATA_WIDTH-1:0]    data;
  } cdb_packet_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source result FIFO feeding the CDB arbiter
module cdb_src_fifo
  import ooo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_push,
  input  logic        i_pop,
  input  cdb_packet_t i_pkt,
  output cdb_packet_t o_head,
  output logic        o_full,
  output logic        o_empty
);

  localparam int PW = $clog2(DEPTH);

  cdb_packet_t      r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];

  // No look-ahead: a full FIFO refuses a push even if it is popped this cycle.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_pkt;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving the registered common data bus
// Optional single-producer bypass of the FIFOs when CDB_BYPASS_EN is defined.
module cdb_arbiter #(
  parameter int  NUM_SRC       = 2,
  parameter int  FIFO_DEPTH    = 4,
  parameter int  DATA_WIDTH    = 32,
  parameter int  TAG_WIDTH     = 6,
  parameter int  ROB_IDX_WIDTH = 5,
  localparam int SRC_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  logic [NUM_SRC-1:0]                      src_valid,
  output logic [NUM_SRC-1:0]                      src_ready,
  input  logic [NUM_SRC-1:0][TAG_WIDTH-1:0]       src_tag,
  input  logic [NUM_SRC-1:0][ROB_IDX_WIDTH-1:0]   src_rob_idx,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]      src_data,
  output logic                                    cdb_valid,
  output logic [TAG_WIDTH-1:0]                    cdb_tag,
  output logic [ROB_IDX_WIDTH-1:0]                cdb_rob_idx,
  output logic [DATA_WIDTH-1:0]                   cdb_data,
  output logic [SRC_W-1:0]                        cdb_src
);

  import ooo_pkg::*;

  cdb_packet_t        w_in_pkt [NUM_SRC];
  cdb_packet_t        w_head   [NUM_SRC];
  cdb_packet_t        w_sel_pkt;
  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic               w_grant;
  logic [SRC_W-1:0]   w_grant_idx;
  logic               w_bypass;
  logic [SRC_W-1:0]   w_byp_idx;
  logic [SRC_W-1:0]   w_win_idx;
  logic [SRC_W-1:0]   w_next_rr;
  logic [SRC_W-1:0]   r_rr_ptr;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_in_pkt[g] = '{tag: src_tag[g], rob_idx: src_rob_idx[g], data: src_data[g]};
    assign src_ready[g] = ~w_full[g];
    assign w_push[g]    = src_valid[g] & ~w_full[g] & ~w_bypass;
    assign w_pop[g]     = w_grant & (w_grant_idx == SRC_W'(g)) & ~flush;

    cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_pkt   (w_in_pkt[g]),
      .o_head  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  // First non-empty FIFO at or after r_rr_ptr, wrapping upward.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_idx = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      int idx;
      idx = (int'(r_rr_ptr) + off) % NUM_SRC;
      if (!w_grant && !w_empty[idx]) begin
        w_grant     = 1'b1;
        w_grant_idx = SRC_W'(idx);
      end
    end
  end

`ifdef CDB_BYPASS_EN
  logic [NUM_SRC-1:0] w_req;
  assign w_req = src_valid & ~w_full;

  always_comb begin
    w_byp_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_req[i]) w_byp_idx = SRC_W'(i);
    end
  end

  // Exactly one requester (one-hot test) while the whole arbiter is idle.
  assign w_bypass = (&w_empty) && (w_req != '0) && ((w_req & (w_req - 1'b1)) == '0) && !flush;
`else
  assign w_bypass  = 1'b0;
  assign w_byp_idx = '0;
`endif

  assign w_win_idx = w_bypass ? w_byp_idx : w_grant_idx;
  assign w_sel_pkt = w_bypass ? w_in_pkt[w_byp_idx] : w_head[w_grant_idx];
  assign w_next_rr = SRC_W'((int'(w_win_idx) + 1) % NUM_SRC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      cdb_valid   <= 1'b0;
      cdb_tag     <= '0;
      cdb_rob_idx <= '0;
      cdb_data    <= '0;
      cdb_src     <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (w_grant || w_bypass) begin
      r_rr_ptr    <= w_next_rr;
      cdb_valid   <= 1'b1;
      cdb_tag     <= w_sel_pkt.tag;
      cdb_rob_idx <= w_sel_pkt.rob_idx;
      cdb_data    <= w_sel_pkt.data;
      cdb_src     <= w_win_idx;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter against a queue-based reference model
module tb_cdb_arbiter;

  localparam int N     = 2;
  localparam int DEPTH = 4;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [N-1:0]      src_valid;
  logic [N-1:0]      src_ready;
  logic [N-1:0][5:0]  src_tag;
  logic [N-1:0][4:0]  src_rob_idx;
  logic [N-1:0][31:0] src_data;
  logic              cdb_valid;
  logic [5:0]        cdb_tag;
  logic [4:0]        cdb_rob_idx;
  logic [31:0]       cdb_data;
  logic [0:0]        cdb_src;

  cdb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_tag     (src_tag),
    .src_rob_idx (src_rob_idx),
    .src_data    (src_data),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_data    (cdb_data),
    .cdb_src     (cdb_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  tag;
    logic [4:0]  rob;
    logic [31:0] data;
    int          src;
  } ent_t;

  ent_t mq [N][$];
  ent_t expq[$];
  int   rr;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input int i);
    ent_t e;
    e.tag  = src_tag[i];
    e.rob  = src_rob_idx[i];
    e.data = src_data[i];
    e.src  = i;
    return e;
  endfunction

  function automatic logic [63:0] pack(input ent_t e);
    logic [0:0] s;
    s = e.src[0:0];
    return {20'h0, s, e.tag, e.rob, e.data};
  endfunction

  // Behavioural model: per-source queues bounded at DEPTH, rotating priority pointer.
  task automatic model_step();
    bit acc[N];
    int nacc;
    int only;
    bool_loop: begin
    end
    nacc = 0;
    only = 0;
    for (int i = 0; i < N; i++) begin
      acc[i] = src_valid[i] && (mq[i].size() < DEPTH);
      if (acc[i]) begin
        nacc++;
        only = i;
      end
    end
    if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      return;
    end
    if (BYP && nacc == 1 && mq[0].size() == 0 && mq[1].size() == 0) begin
      expq.push_back(mk(only));
      rr = (only + 1) % N;
      return;
    end
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = (rr + off) % N;
      if (mq[idx].size() > 0) begin
        expq.push_back(mq[idx].pop_front());
        rr = (idx + 1) % N;
        break;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) mq[i].push_back(mk(i));
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) model_step();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++)
        chk($sformatf("src_ready[%0d]", i), 64'(src_ready[i]), 64'(mq[i].size() < DEPTH));
      if (cdb_valid) begin
        if (expq.size() == 0) begin
          chk("spurious_broadcast", 64'(cdb_valid), 64'd0);
        end else begin
          ent_t e;
          e = expq.pop_front();
          chk("cdb_packet", {20'h0, cdb_src, cdb_tag, cdb_rob_idx, cdb_data}, pack(e));
        end
      end else if (expq.size() > 0) begin
        chk("missing_broadcast", 64'(cdb_valid), 64'd1);
        void'(expq.pop_front());
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic f);
    @(negedge clk);
    src_valid = v;
    flush     = f;
    for (int i = 0; i < N; i++) begin
      src_tag[i]     = 6'($urandom);
      src_rob_idx[i] = 5'($urandom);
      src_data[i]    = $urandom;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) mq[i].delete();
    expq.delete();
    rr = 0;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rr          = 0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    src_valid   = '0;
    src_tag     = '0;
    src_rob_idx = '0;
    src_data    = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    repeat (5) begin
      @(negedge clk);
      chk("idle_valid", 64'(cdb_valid), 64'd0);
      chk("idle_ready", 64'(src_ready), 64'd3);
    end

    @(negedge clk);
    src_valid      = 2'b01;
    src_tag[0]     = 6'h05;
    src_rob_idx[0] = 5'd3;
    src_data[0]    = 32'hDEADBEEF;
    @(negedge clk);
    src_valid = '0;
    chk("lat_edge_k_valid", 64'(cdb_valid), 64'(BYP));
    @(negedge clk);
    chk("lat_edge_k1_valid", 64'(cdb_valid), 64'(!BYP));
    chk("single_tag", 64'(cdb_tag), 64'h05);
    chk("single_rob", 64'(cdb_rob_idx), 64'd3);
    chk("single_data", 64'(cdb_data), 64'hDEADBEEF);
    chk("single_src", 64'(cdb_src), 64'd0);
    repeat (3) drive(2'b00, 1'b0);

    repeat (12) drive(2'b11, 1'b0);
    repeat (6) drive(2'b10, 1'b0);
    repeat (16) drive(2'b00, 1'b0);

    repeat (3) drive(2'b11, 1'b0);
    drive(2'b01, 1'b1);
    drive(2'b00, 1'b0);
    chk("flush_valid", 64'(cdb_valid), 64'd0);
    chk("flush_ready", 64'(src_ready), 64'd3);
    repeat (4) drive(2'b00, 1'b0);

    repeat (5) drive(2'b11, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("async_rst_valid", 64'(cdb_valid), 64'd0);
    chk("async_rst_ready", 64'(src_ready), 64'd3);
    @(negedge clk);
    src_valid = '0;
    flush     = 1'b0;
    rst_n     = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(cdb_valid), 64'd0);
    end

    repeat (400) drive(2'($urandom), ($urandom_range(0, 19) == 0));

    drive(2'b00, 1'b0);
    for (int c = 0; c < 30 && expq.size() + mq[0].size() + mq[1].size() > 0; c++)
      @(negedge clk);
    @(negedge clk);
    chk("drain_pending", 64'(expq.size() + mq[0].size() + mq[1].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
